local_sram_controller: RTL and testbench
========================================

Name: local_sram_controller

Overview:
- Sits directly downstream of the Wishbone SRAM interface's local-memory port and alongside the core's own data-memory port.
- Arbitrates both requesters onto two single-port 32-bit SRAM macro banks of 512 words each (4 KB total).
- Sequences each macro access with its registered-input, one-cycle read latency.
- Returns read data and a busy handshake that matches the requester protocol: a request is held until busy drops, and data is valid in that same cycle.

Parameters:
- WORD_ADDRESS_BITS, 9, word index width per bank (512 words).
- BANK_SELECT_BIT, 11, byte-address bit that selects bank 1.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_n_i  in  1  asynchronous active-low reset
- peripheral_address  in  24  byte address from the Wishbone interface
- peripheral_byteSelect  in  4  byte lanes
- peripheral_writeEnable  in  1  write request
- peripheral_readEnable  in  1  read request
- peripheral_dataWrite  in  32  write data
- peripheral_dataRead  out  32  read data
- peripheral_busy  out  1  request not yet complete
- core_address, core_byteSelect, core_writeEnable, core_readEnable, core_dataWrite  in  24/4/1/1/32  core port, same meaning as the peripheral signals
- core_dataRead  out  32  read data
- core_busy  out  1  request not yet complete
- sram_csb  out  2  per-bank chip select, active low
- sram_web  out  1  write enable, active low, shared by both banks
- sram_wmask  out  4  byte write mask, shared
- sram_addr  out  9  word address, shared
- sram_din  out  32  write data, shared
- sram0_dout  in  32  bank 0 read data
- sram1_dout  in  32  bank 1 read data

Behaviour:
- Request: a port requests when writeEnable or readEnable is high. If both are high, the write wins.
- Busy: x_busy = request_x && !(state==DONE && grant==x). This is combinational, so busy is high in the same cycle the request appears.
- Decode, from the latched address:
  - Word index = addr[10:2]; bank = addr[BANK_SELECT_BIT].
  - If addr[23:12] != 0 the request is out of range: no macro access, reads return 32'h0, writes are dropped.
- FSM states: IDLE, ACCESS, READ_WAIT, DONE.
- IDLE:
  - Any request: arbitrate, latch grant/address/byteSelect/dataWrite/isWrite.
  - In range: load the macro output registers (csb[bank]=0, web=!isWrite, wmask = byteSelect for writes and 0 for reads, addr, din), then go to ACCESS.
  - Out of range: load a zero read register, go to DONE.
- ACCESS:
  - Macro samples its inputs at the end of this cycle.
  - Drive csb=2'b11 and web=1 from the next cycle.
  - Write: go to DONE. Read: go to READ_WAIT.
- READ_WAIT: capture sram{bank}_dout into readData, go to DONE.
- DONE:
  - Granted port sees busy=0 for exactly one cycle.
  - The FSM goes to IDLE unconditionally; a request still asserted in the IDLE cycle is a new transaction.
- Latency, counting the request's first cycle as cycle 0:
  - Read busy is high in cycles 0–2 and low in cycle 3.
  - In-range write busy is low in cycle 2.
  - Out-of-range access busy is low in cycle 1.
- Read data:
  - x_dataRead = readData while grant==x, else 32'h0.
  - readData holds its value until the next read capture.
- Arbitration:
  - Single requester: granted.
  - Both requesting in IDLE: the port not granted last wins. lastGrant resets to peripheral, so the core wins the first tie.
  - The loser stays busy with no other effect.
- Reset (asynchronous, mid-transaction included):
  - state=IDLE, sram_csb=2'b11, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0, readData=0, grant=core, lastGrant=peripheral.
  - While reset is asserted, busy = request. Requesters re-issue after reset.
- Request inputs are ignored outside IDLE, apart from busy generation.

Decomposition:
- Shared package (local_sram_pkg):
  - FSM state encoding (2-bit).
  - Bank geometry constants: word bits, bank bit, in-range mask.
  - Port-ID constants: PORT_CORE=0, PORT_PERIPHERAL=1.
- One sub-module, sram_port_arbiter:
  - Two-request round-robin with a lastGrant register, updated on grant in IDLE.
  - Outputs the grant id and a grant-valid signal.

Test Plan:
- Peripheral write 0x000010 = 0xDEADBEEF, sel 4'hF; then peripheral read 0x000010:
  - csb=2'b10 for one cycle on each access.
  - Write busy is low in cycle 2; read busy is low in cycle 3 with dataRead=0xDEADBEEF.
- Core write to 0x000804 (bank 1), sel 4'b0011, data 0x12345678, over prior contents 0xAAAAAAAA:
  - csb=2'b01, wmask=4'b0011.
  - Readback = 0xAAAA5678.
- Both ports request reads in the same cycle after reset:
  - Core is served first (busy low cycle 3); peripheral is served next.
  - Repeating the tie serves the other port first.
- Peripheral read of 0x001000 (out of range): no csb activity, busy low in cycle 1, dataRead=0x00000000.
- Assert reset during READ_WAIT:
  - csb=2'b11 and web=1 immediately, state IDLE.
  - A re-issued read after release returns the correct data.
- Back-to-back: the requester keeps readEnable high through DONE:
  - A second full 3-cycle transaction starts from IDLE.
  - Busy shows exactly one low cycle per transaction.

Source files
------------

// File: rtl/local_sram_pkg.sv
// Shared definitions for the local SRAM controller: FSM encoding, bank geometry,
// port ids and the requester payload.
package local_sram_pkg;

    localparam int unsigned ADDR_BITS = 24;
    localparam int unsigned DATA_BITS = 32;
    localparam int unsigned SEL_BITS  = 4;
    localparam int unsigned WORD_BITS = 9;
    localparam int unsigned BANK_BIT  = 11;

    // Address bits that must be zero for the access to land in the 4 KB macro pair.
    localparam logic [ADDR_BITS-1:0] OUT_OF_RANGE_MASK = 24'hFFF000;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ACCESS    = 2'd1;
    localparam logic [1:0] ST_READ_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    localparam logic PORT_CORE       = 1'b0;
    localparam logic PORT_PERIPHERAL = 1'b1;

    typedef struct packed {
        logic [ADDR_BITS-1:0] address;
        logic [SEL_BITS-1:0]  byte_select;
        logic                 write_enable;
        logic                 read_enable;
        logic [DATA_BITS-1:0] data_write;
    } sram_req_t;

    function automatic logic addr_in_range(input logic [ADDR_BITS-1:0] addr);
        return (addr & OUT_OF_RANGE_MASK) == '0;
    endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// Two-requester round-robin: on a tie the port not granted last wins.
module sram_port_arbiter
    import local_sram_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_core,
    input  logic req_peripheral,
    input  logic update,
    output logic grant_id_c,
    output logic grant_valid_c
);

    logic last_grant_q;

    always_comb begin
        grant_valid_c = req_core | req_peripheral;
        grant_id_c    = PORT_CORE;
        if (req_core && req_peripheral) begin
            grant_id_c = ~last_grant_q;
        end else if (req_peripheral) begin
            grant_id_c = PORT_PERIPHERAL;
        end
    end

    // Reset to peripheral so the core wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= PORT_PERIPHERAL;
        end else if (update && grant_valid_c) begin
            last_grant_q <= grant_id_c;
        end
    end

endmodule

// File: rtl/local_sram_controller.sv
// Arbitrates the core and Wishbone peripheral ports onto two 512x32 single-port
// SRAM macros with registered inputs and one-cycle read latency.
module local_sram_controller
    import local_sram_pkg::*;
#(
    parameter int unsigned WORD_ADDRESS_BITS = WORD_BITS,
    parameter int unsigned BANK_SELECT_BIT   = BANK_BIT
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_n_i,
    input  logic [23:0]                  peripheral_address,
    input  logic [3:0]                   peripheral_byteSelect,
    input  logic                         peripheral_writeEnable,
    input  logic                         peripheral_readEnable,
    input  logic [31:0]                  peripheral_dataWrite,
    output logic [31:0]                  peripheral_dataRead,
    output logic                         peripheral_busy,
    input  logic [23:0]                  core_address,
    input  logic [3:0]                   core_byteSelect,
    input  logic                         core_writeEnable,
    input  logic                         core_readEnable,
    input  logic [31:0]                  core_dataWrite,
    output logic [31:0]                  core_dataRead,
    output logic                         core_busy,
    output logic [1:0]                   sram_csb,
    output logic                         sram_web,
    output logic [3:0]                   sram_wmask,
    output logic [WORD_ADDRESS_BITS-1:0] sram_addr,
    output logic [31:0]                  sram_din,
    input  logic [31:0]                  sram0_dout,
    input  logic [31:0]                  sram1_dout
);

    sram_req_t core_req;
    sram_req_t periph_req;
    sram_req_t sel_req;

    logic core_request_c;
    logic periph_request_c;
    logic grant_id_c;
    logic grant_valid_c;

    logic [1:0]                   state_q,     state_d;
    logic                         grant_q,     grant_d;
    logic                         is_write_q,  is_write_d;
    logic                         bank_q,      bank_d;
    logic [1:0]                   csb_q,       csb_d;
    logic                         web_q,       web_d;
    logic [3:0]                   wmask_q,     wmask_d;
    logic [WORD_ADDRESS_BITS-1:0] addr_q,      addr_d;
    logic [31:0]                  din_q,       din_d;
    logic [31:0]                  read_data_q, read_data_d;

    assign core_req   = '{address: core_address, byte_select: core_byteSelect,
                          write_enable: core_writeEnable, read_enable: core_readEnable,
                          data_write: core_dataWrite};
    assign periph_req = '{address: peripheral_address, byte_select: peripheral_byteSelect,
                          write_enable: peripheral_writeEnable, read_enable: peripheral_readEnable,
                          data_write: peripheral_dataWrite};

    assign core_request_c   = core_writeEnable | core_readEnable;
    assign periph_request_c = peripheral_writeEnable | peripheral_readEnable;
    assign sel_req          = (grant_id_c == PORT_CORE) ? core_req : periph_req;

    // Byte offset and the read flag (write wins when both are set) carry no decode.
    logic unused_sel_bits;
    assign unused_sel_bits = ^{sel_req.read_enable, sel_req.address[1:0]};

    sram_port_arbiter u_arbiter (
        .clk            (wb_clk_i),
        .rst_n          (wb_rst_n_i),
        .req_core       (core_request_c),
        .req_peripheral (periph_request_c),
        .update         (state_q == ST_IDLE),
        .grant_id_c     (grant_id_c),
        .grant_valid_c  (grant_valid_c)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= ST_IDLE;
            grant_q     <= PORT_CORE;
            is_write_q  <= 1'b0;
            bank_q      <= 1'b0;
            csb_q       <= 2'b11;
            web_q       <= 1'b1;
            wmask_q     <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            is_write_q  <= is_write_d;
            bank_q      <= bank_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            wmask_q     <= wmask_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            read_data_q <= read_data_d;
        end
    end

    // Next state and next macro-pin values; macro pins are registered.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        is_write_d  = is_write_q;
        bank_d      = bank_q;
        csb_d       = csb_q;
        web_d       = web_q;
        wmask_d     = wmask_q;
        addr_d      = addr_q;
        din_d       = din_q;
        read_data_d = read_data_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid_c) begin
                    grant_d    = grant_id_c;
                    is_write_d = sel_req.write_enable;
                    bank_d     = sel_req.address[BANK_SELECT_BIT];
                    if (addr_in_range(sel_req.address)) begin
                        csb_d         = 2'b11;
                        csb_d[bank_d] = 1'b0;
                        web_d         = ~sel_req.write_enable;
                        wmask_d       = sel_req.write_enable ? sel_req.byte_select : 4'b0000;
                        addr_d        = sel_req.address[WORD_ADDRESS_BITS+1:2];
                        din_d         = sel_req.data_write;
                        state_d       = ST_ACCESS;
                    end else begin
                        read_data_d = '0;
                        state_d     = ST_DONE;
                    end
                end
            end
            ST_ACCESS: begin
                csb_d   = 2'b11;
                web_d   = 1'b1;
                state_d = is_write_q ? ST_DONE : ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                read_data_d = bank_q ? sram1_dout : sram0_dout;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sram_csb   = csb_q;
    assign sram_web   = web_q;
    assign sram_wmask = wmask_q;
    assign sram_addr  = addr_q;
    assign sram_din   = din_q;

    // Busy drops only for the granted port in DONE, so it rises with the request.
    assign core_busy       = core_request_c   && !(state_q == ST_DONE && grant_q == PORT_CORE);
    assign peripheral_busy = periph_request_c && !(state_q == ST_DONE && grant_q == PORT_PERIPHERAL);

    assign core_dataRead       = (grant_q == PORT_CORE)       ? read_data_q : 32'h0;
    assign peripheral_dataRead = (grant_q == PORT_PERIPHERAL) ? read_data_q : 32'h0;

endmodule

// File: tb/tb_local_sram_controller.sv
// Directed bench for local_sram_controller with a behavioural model of the two
// SRAM macros (registered inputs, one-cycle read latency).
module tb_local_sram_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] p_addr, c_addr;
    logic [3:0]  p_sel, c_sel;
    logic        p_we, p_re, c_we, c_re;
    logic [31:0] p_wdata, c_wdata;
    logic [31:0] p_rdata, c_rdata;
    logic        p_busy, c_busy;
    logic [1:0]  sram_csb;
    logic        sram_web;
    logic [3:0]  sram_wmask;
    logic [8:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram0_dout, sram1_dout;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    local_sram_controller dut (
        .wb_clk_i              (clk),
        .wb_rst_n_i            (rst_n),
        .peripheral_address    (p_addr),
        .peripheral_byteSelect (p_sel),
        .peripheral_writeEnable(p_we),
        .peripheral_readEnable (p_re),
        .peripheral_dataWrite  (p_wdata),
        .peripheral_dataRead   (p_rdata),
        .peripheral_busy       (p_busy),
        .core_address          (c_addr),
        .core_byteSelect       (c_sel),
        .core_writeEnable      (c_we),
        .core_readEnable       (c_re),
        .core_dataWrite        (c_wdata),
        .core_dataRead         (c_rdata),
        .core_busy             (c_busy),
        .sram_csb              (sram_csb),
        .sram_web              (sram_web),
        .sram_wmask            (sram_wmask),
        .sram_addr             (sram_addr),
        .sram_din              (sram_din),
        .sram0_dout            (sram0_dout),
        .sram1_dout            (sram1_dout)
    );

    // Macro model: inputs sampled at the clock edge, read data available next cycle.
    logic [31:0] mem0 [512];
    logic [31:0] mem1 [512];

    always_ff @(posedge clk) begin
        if (!sram_csb[0]) begin
            if (!sram_web) begin
                for (int i = 0; i < 4; i++)
                    if (sram_wmask[i]) mem0[sram_addr][8*i +: 8] <= sram_din[8*i +: 8];
            end else begin
                sram0_dout <= mem0[sram_addr];
            end
        end
        if (!sram_csb[1]) begin
            if (!sram_web) begin
                for (int i = 0; i < 4; i++)
                    if (sram_wmask[i]) mem1[sram_addr][8*i +: 8] <= sram_din[8*i +: 8];
            end else begin
                sram1_dout <= mem1[sram_addr];
            end
        end
    end

    typedef struct {
        logic        is_core;
        logic        we;
        logic        re;
        logic [23:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          exp_low;
        logic [1:0]  exp_csb;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic is_core, input logic we, input logic re,
                                input logic [23:0] addr, input logic [3:0] sel,
                                input logic [31:0] wdata, input int exp_low,
                                input logic [1:0] exp_csb, input logic [3:0] exp_wmask,
                                input logic [31:0] exp_rdata);
        vec_t v;
        v.is_core = is_core; v.we = we; v.re = re; v.addr = addr; v.sel = sel;
        v.wdata = wdata; v.exp_low = exp_low; v.exp_csb = exp_csb;
        v.exp_wmask = exp_wmask; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic clear_ports();
        p_addr = '0; p_sel = '0; p_we = 0; p_re = 0; p_wdata = '0;
        c_addr = '0; c_sel = '0; c_we = 0; c_re = 0; c_wdata = '0;
    endtask

    task automatic drive(input vec_t v);
        if (v.is_core) begin
            c_addr = v.addr; c_sel = v.sel; c_we = v.we; c_re = v.re; c_wdata = v.wdata;
        end else begin
            p_addr = v.addr; p_sel = v.sel; p_we = v.we; p_re = v.re; p_wdata = v.wdata;
        end
    endtask

    // One transaction on one port; cycle 0 is the first cycle the request is seen.
    task automatic run_txn(input vec_t v, input int idx);
        int          low_cyc = -1;
        int          csb_cycles = 0;
        logic [1:0]  csb_acc = 2'b11;
        logic [3:0]  wm = 4'h0;
        logic [31:0] rd = '0;
        logic [31:0] other = '0;
        logic        busy;
        string       tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        drive(v);
        #1;
        for (int c = 0; c < 8 && low_cyc < 0; c++) begin
            if (c > 0) @(negedge clk);
            if (sram_csb != 2'b11) begin
                csb_cycles++;
                csb_acc &= sram_csb;
                wm = sram_wmask;
            end
            busy = v.is_core ? c_busy : p_busy;
            if (!busy) begin
                low_cyc = c;
                rd      = v.is_core ? c_rdata : p_rdata;
                other   = v.is_core ? p_rdata : c_rdata;
            end
        end
        @(negedge clk);
        clear_ports();
        chk({tag, " busy_low_cycle"}, 32'(low_cyc), 32'(v.exp_low));
        chk({tag, " csb"}, 32'(csb_acc), 32'(v.exp_csb));
        chk({tag, " csb_cycles"}, 32'(csb_cycles), (v.exp_csb == 2'b11) ? 32'd0 : 32'd1);
        if (v.exp_csb != 2'b11) chk({tag, " wmask"}, 32'(wm), 32'(v.exp_wmask));
        if (v.re && !v.we) chk({tag, " rdata"}, rd, v.exp_rdata);
        chk({tag, " other_rdata"}, other, 32'h0);
    endtask

    // Both ports issue reads together; each drops its request after its done cycle.
    task automatic run_tie(input string tag, input logic [23:0] ca, input logic [23:0] pa,
                           input int exp_c_low, input int exp_p_low,
                           input logic [31:0] exp_c, input logic [31:0] exp_p);
        int          c_low = -1;
        int          p_low = -1;
        logic [31:0] c_rd = '0;
        logic [31:0] p_rd = '0;
        @(negedge clk);
        c_addr = ca; c_sel = 4'hF; c_re = 1;
        p_addr = pa; p_sel = 4'hF; p_re = 1;
        #1;
        for (int c = 0; c < 14 && (c_low < 0 || p_low < 0); c++) begin
            if (c > 0) begin
                @(negedge clk);
                if (c_low >= 0) c_re = 0;
                if (p_low >= 0) p_re = 0;
            end
            if (c_low < 0 && !c_busy) begin c_low = c; c_rd = c_rdata; end
            if (p_low < 0 && !p_busy) begin p_low = c; p_rd = p_rdata; end
        end
        @(negedge clk);
        clear_ports();
        chk({tag, " core_low_cycle"}, 32'(c_low), 32'(exp_c_low));
        chk({tag, " periph_low_cycle"}, 32'(p_low), 32'(exp_p_low));
        chk({tag, " core_rdata"}, c_rd, exp_c);
        chk({tag, " periph_rdata"}, p_rd, exp_p);
    endtask

    vec_t vecs[16];

    initial begin
        logic exp_busy [8];
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

        //        core we  re  addr        sel     wdata          low csb    wmask   rdata
        vecs[0]  = mk(0, 1, 0, 24'h000010, 4'hF, 32'hDEADBEEF, 2, 2'b10, 4'hF, 32'h0);
        vecs[1]  = mk(0, 0, 1, 24'h000010, 4'hF, 32'h0,        3, 2'b10, 4'h0, 32'hDEADBEEF);
        vecs[2]  = mk(1, 1, 0, 24'h000804, 4'hF, 32'hAAAAAAAA, 2, 2'b01, 4'hF, 32'h0);
        vecs[3]  = mk(1, 1, 0, 24'h000804, 4'h3, 32'h12345678, 2, 2'b01, 4'h3, 32'h0);
        vecs[4]  = mk(1, 0, 1, 24'h000804, 4'hF, 32'h0,        3, 2'b01, 4'h0, 32'hAAAA5678);
        vecs[5]  = mk(0, 0, 1, 24'h001000, 4'hF, 32'h0,        1, 2'b11, 4'h0, 32'h0);
        vecs[6]  = mk(1, 1, 0, 24'h000000, 4'hF, 32'h0BADF00D, 2, 2'b10, 4'hF, 32'h0);
        vecs[7]  = mk(0, 1, 0, 24'h001000, 4'hF, 32'hFFFFFFFF, 1, 2'b11, 4'h0, 32'h0);
        vecs[8]  = mk(1, 1, 0, 24'h000800, 4'hF, 32'h11112222, 2, 2'b01, 4'hF, 32'h0);
        vecs[9]  = mk(1, 0, 1, 24'h000000, 4'hF, 32'h0,        3, 2'b10, 4'h0, 32'h0BADF00D);
        vecs[10] = mk(0, 1, 0, 24'h000804, 4'hC, 32'h99990000, 2, 2'b01, 4'hC, 32'h0);
        vecs[11] = mk(0, 0, 1, 24'h000804, 4'hF, 32'h0,        3, 2'b01, 4'h0, 32'h99995678);
        vecs[12] = mk(1, 0, 1, 24'h000800, 4'hF, 32'h0,        3, 2'b01, 4'h0, 32'h11112222);
        vecs[13] = mk(0, 0, 1, 24'h800010, 4'hF, 32'h0,        1, 2'b11, 4'h0, 32'h0);
        vecs[14] = mk(1, 1, 1, 24'h000014, 4'hF, 32'h5A5A5A5A, 2, 2'b10, 4'hF, 32'h0);
        vecs[15] = mk(1, 0, 1, 24'h000014, 4'hF, 32'h0,        3, 2'b10, 4'h0, 32'h5A5A5A5A);

        clear_ports();
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("reset csb", 32'(sram_csb), 32'h3);
        chk("reset web", 32'(sram_web), 32'h1);
        chk("reset wmask", 32'(sram_wmask), 32'h0);
        chk("reset addr", 32'(sram_addr), 32'h0);
        chk("reset din", sram_din, 32'h0);
        chk("reset core_rdata", c_rdata, 32'h0);
        chk("reset busy", 32'({c_busy, p_busy}), 32'h0);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) run_txn(vecs[i], i);

        // Tie straight after reset goes to the core.
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        run_tie("tie1", 24'h000000, 24'h000800, 3, 7, 32'h0BADF00D, 32'h11112222);
        run_txn(vecs[9], 9);
        run_tie("tie2", 24'h000804, 24'h000014, 7, 3, 32'h99995678, 32'h5A5A5A5A);

        // Reset while a read sits in READ_WAIT, then re-issue it.
        @(negedge clk);
        p_addr = 24'h000010; p_sel = 4'hF; p_re = 1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid state_before", 32'(dut.state_q), 32'h2);
        #2 rst_n = 0;
        #1;
        chk("rst_mid csb", 32'(sram_csb), 32'h3);
        chk("rst_mid web", 32'(sram_web), 32'h1);
        chk("rst_mid state", 32'(dut.state_q), 32'h0);
        chk("rst_mid busy", 32'(p_busy), 32'h1);
        chk("rst_mid core_rdata", c_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1;
        clear_ports();
        run_txn(vecs[1], 101);

        // Back-to-back: core holds readEnable through DONE.
        @(negedge clk);
        c_addr = 24'h000000; c_sel = 4'hF; c_re = 1;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            chk($sformatf("b2b busy_c%0d", c), 32'(c_busy), 32'(exp_busy[c]));
            if (c == 3 || c == 7)
                chk($sformatf("b2b rdata_c%0d", c), c_rdata, 32'h0BADF00D);
        end
        @(negedge clk);
        clear_ports();
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "bench timeout");
    end

endmodule
